// File: rtl/des_pkg.sv
// Shared state encoding, round constants and key-rotate schedule for the
// iterative DES round controller.
package des_pkg;

    localparam int NUM_ROUNDS = 16;
    localparam int ITER_W     = 4;
    localparam logic [ITER_W-1:0] LAST_ROUND = ITER_W'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FIN,
        DONE
    } state_t;

    // Decrypt undoes the encrypt rotations in reverse order, so its first
    // round uses the PC-1 state as loaded (total left rotation is 28).
    function automatic logic [1:0] shift_amount(input logic [ITER_W-1:0] round,
                                                input logic              decrypt);
        logic [1:0] amt;
        case (round)
            4'd0:              amt = decrypt ? 2'd0 : 2'd1;
            4'd1, 4'd8, 4'd15: amt = 2'd1;
            default:           amt = 2'd2;
        endcase
        return amt;
    endfunction

endpackage

// File: rtl/des_shift_sched.sv
// Per-round key-rotate amount, forced to zero on cycles without a round.
module des_shift_sched
    import des_pkg::*;
(
    input  logic              en,
    input  logic [ITER_W-1:0] iter,
    input  logic              decrypt,
    output logic [1:0]        shift
);

    assign shift = en ? shift_amount(iter, decrypt) : 2'd0;

endmodule

// File: rtl/des_round_ctrl.sv
// Sequencer for a one-round-per-clock DES datapath: request capture, load
// cycle, 16 rounds, result capture and a backpressure-tolerant response port.
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int KEY_W  = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_decrypt_i,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic [KEY_W-1:0]  req_key_i,

    output logic              rnd_start_o,
    output logic              rnd_en_o,
    output logic [3:0]        rnd_iter_o,
    output logic              rnd_decrypt_o,
    output logic [1:0]        rnd_shift_o,
    output logic [DATA_W-1:0] rnd_data_o,
    output logic [KEY_W-1:0]  rnd_key_o,
    input  logic [DATA_W-1:0] rnd_result_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,

    output logic              busy_o
);

    state_t              state;
    state_t              state_next;
    logic [ITER_W-1:0]   iter;
    logic                decrypt_q;
    logic [DATA_W-1:0]   data_q;
    logic [KEY_W-1:0]    key_q;
    logic [DATA_W-1:0]   rsp_q;
    logic                accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready is withheld while reset is held so nothing is offered before the
    // controller is actually able to capture a request.
    always_comb begin
        state_next  = state;
        req_ready_o = 1'b0;
        rnd_start_o = 1'b0;
        rnd_en_o    = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (state)
            IDLE: begin
                busy_o      = 1'b0;
                req_ready_o = ~reset;
                if (req_valid_i) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                rnd_start_o = 1'b1;
                state_next  = ROUND;
            end
            ROUND: begin
                rnd_en_o = 1'b1;
                if (iter == LAST_ROUND) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = DONE;
            end
            DONE: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept = req_valid_i & req_ready_o;

    // Operands are only sampled on accept, so inputs may change freely while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iter      <= '0;
            decrypt_q <= 1'b0;
            data_q    <= '0;
            key_q     <= '0;
            rsp_q     <= '0;
        end else begin
            if (accept) begin
                decrypt_q <= req_decrypt_i;
                data_q    <= req_data_i;
                key_q     <= req_key_i;
            end
            case (state)
                LOAD: begin
                    iter <= '0;
                end
                ROUND: begin
                    if (iter != LAST_ROUND) begin
                        iter <= iter + ITER_W'(1);
                    end
                end
                FIN: begin
                    rsp_q <= rnd_result_i;
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        iter <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    des_shift_sched u_shift_sched (
        .en      (rnd_en_o),
        .iter    (iter),
        .decrypt (decrypt_q),
        .shift   (rnd_shift_o)
    );

    assign rnd_iter_o    = iter;
    assign rnd_decrypt_o = decrypt_q;
    assign rnd_data_o    = data_q;
    assign rnd_key_o     = key_q;
    assign rsp_data_o    = rsp_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl; a behavioural DES round model driven by the
// controller's round outputs supplies rnd_result_i.
module tb_des_round_ctrl;

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT2  = 64'h8787878787878787;
    localparam logic [63:0] CT2  = 64'h0000000000000000;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam logic [255:0] SBOX_T [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_decrypt_i = 1'b0;
    logic [63:0] req_data_i = '0;
    logic [63:0] req_key_i = '0;
    logic        rnd_start_o;
    logic        rnd_en_o;
    logic [3:0]  rnd_iter_o;
    logic        rnd_decrypt_o;
    logic [1:0]  rnd_shift_o;
    logic [63:0] rnd_data_o;
    logic [63:0] rnd_key_o;
    logic [63:0] rnd_result_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [63:0] rsp_data_o;
    logic        busy_o;

    int          checks = 0;
    int          errors = 0;
    int          lat;
    int          start_cnt;
    int          en_cnt;
    int          shift_sum;
    logic [31:0] shift_seq;
    logic        held_ok;
    logic        iter_ok;

    always #5 clk = ~clk;

    des_round_ctrl #(.DATA_W(64), .KEY_W(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_decrypt_i (req_decrypt_i),
        .req_data_i    (req_data_i),
        .req_key_i     (req_key_i),
        .rnd_start_o   (rnd_start_o),
        .rnd_en_o      (rnd_en_o),
        .rnd_iter_o    (rnd_iter_o),
        .rnd_decrypt_o (rnd_decrypt_o),
        .rnd_shift_o   (rnd_shift_o),
        .rnd_data_o    (rnd_data_o),
        .rnd_key_o     (rnd_key_o),
        .rnd_result_i  (rnd_result_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .busy_o        (busy_o)
    );

    function automatic logic [63:0] doIp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] doFp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] doPc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] doPc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0]  e;
        logic [31:0]  s;
        logic [31:0]  p;
        logic [5:0]   six;
        logic [255:0] box;
        int           idx;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            six = e[47-6*j -: 6];
            idx = int'({six[5], six[0]}) * 16 + int'(six[4:1]);
            box = SBOX_T[j];
            s[31-4*j -: 4] = box[255-4*idx -: 4];
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
        return p;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] c, input logic [1:0] n,
                                          input logic right);
        logic [55:0] t;
        t = {c, c};
        return right ? t[27+int'(n) -: 28] : t[55-int'(n) -: 28];
    endfunction

    // Reference round datapath: loads on rnd_start_o, runs one round per rnd_en_o.
    logic [31:0] m_l, m_r;
    logic [27:0] m_c, m_d, c_next, d_next;
    logic [47:0] sub_key;

    assign c_next       = rot28(m_c, rnd_shift_o, rnd_decrypt_o);
    assign d_next       = rot28(m_d, rnd_shift_o, rnd_decrypt_o);
    assign sub_key      = doPc2({c_next, d_next});
    assign rnd_result_i = doFp({m_r, m_l});

    always @(posedge clk) begin
        if (rnd_start_o) begin
            {m_l, m_r} <= doIp(rnd_data_o);
            {m_c, m_d} <= doPc1(rnd_key_o);
        end else if (rnd_en_o) begin
            m_l <= m_r;
            m_r <= m_l ^ feistel(m_r, sub_key);
            m_c <= c_next;
            m_d <= d_next;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents a request, waits (bounded) for the accept edge, then scrambles the
    // request inputs so any late sampling shows up in the result.
    task automatic applyStimulus(input logic dec, input logic [63:0] data,
                                 input logic [63:0] key);
        int waited = 0;
        req_decrypt_i = dec;
        req_data_i    = data;
        req_key_i     = key;
        req_valid_i   = 1'b1;
        while (!req_ready_o && waited < 50) begin
            step();
            waited++;
        end
        checkOutput("accept_ready", 64'(req_ready_o), 64'd1);
        step();
        req_valid_i   = 1'b0;
        req_decrypt_i = ~dec;
        req_data_i    = ~data;
        req_key_i     = ~key;
    endtask

    // Called in the LOAD cycle; walks to DONE logging round activity.
    task automatic runToDone(input logic dec, input logic [63:0] data,
                             input logic [63:0] key);
        lat = 1; start_cnt = 0; en_cnt = 0; shift_sum = 0; shift_seq = '0;
        held_ok = 1'b1; iter_ok = 1'b1;
        while (!rsp_valid_o && lat < 40) begin
            if (rnd_start_o) begin
                start_cnt++;
                if (rnd_iter_o != 4'd0) iter_ok = 1'b0;
            end
            if (rnd_en_o) begin
                if (rnd_iter_o != 4'(en_cnt)) iter_ok = 1'b0;
                en_cnt++;
                shift_sum += int'(rnd_shift_o);
                shift_seq = {shift_seq[29:0], rnd_shift_o};
            end else if (rnd_shift_o != 2'd0) begin
                held_ok = 1'b0;
            end
            if (rnd_decrypt_o !== dec || rnd_data_o !== data || rnd_key_o !== key
                || busy_o !== 1'b1 || req_ready_o !== 1'b0) held_ok = 1'b0;
            step();
            lat++;
        end
    endtask

    task automatic finishResponse();
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        checkOutput("post_rsp_valid", 64'(rsp_valid_o), 64'd0);
        checkOutput("post_rsp_ready", 64'(req_ready_o), 64'd1);
        checkOutput("post_rsp_iter", 64'(rnd_iter_o), 64'd0);
        checkOutput("post_rsp_busy", 64'(busy_o), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic        stable_ok;
        int          waited;
        int          cyc;
        int          n_rsp;
        logic        switched;
        int          rsp_cyc [2];
        logic [63:0] rsp_val [2];

        // Reset state
        step();
        step();
        checkOutput("rst_start", 64'(rnd_start_o), 64'd0);
        checkOutput("rst_en", 64'(rnd_en_o), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_iter", 64'(rnd_iter_o), 64'd0);
        checkOutput("rst_rsp_data", rsp_data_o, 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_release_ready", 64'(req_ready_o), 64'd1);
        step();

        // Encrypt known vector
        applyStimulus(1'b0, PT1, KEY1);
        runToDone(1'b0, PT1, KEY1);
        checkOutput("enc_latency", 64'(lat), 64'd19);
        checkOutput("enc_start_pulses", 64'(start_cnt), 64'd1);
        checkOutput("enc_en_cycles", 64'(en_cnt), 64'd16);
        checkOutput("enc_shift_sum", 64'(shift_sum), 64'd28);
        checkOutput("enc_shift_seq", 64'(shift_seq), 64'h5AAA6AA9);
        checkOutput("enc_iter_seq", 64'(iter_ok), 64'd1);
        checkOutput("enc_held", 64'(held_ok), 64'd1);
        checkOutput("enc_result", rsp_data_o, CT1);
        finishResponse();

        // Decrypt known vector
        applyStimulus(1'b1, CT1, KEY1);
        runToDone(1'b1, CT1, KEY1);
        checkOutput("dec_latency", 64'(lat), 64'd19);
        checkOutput("dec_shift_sum", 64'(shift_sum), 64'd27);
        checkOutput("dec_shift_seq", 64'(shift_seq), 64'h1AAA6AA9);
        checkOutput("dec_held", 64'(held_ok), 64'd1);
        checkOutput("dec_result", rsp_data_o, PT1);
        finishResponse();

        // Backpressure in DONE with a competing request
        applyStimulus(1'b0, PT1, KEY1);
        runToDone(1'b0, PT1, KEY1);
        checkOutput("bp_first_result", rsp_data_o, CT1);
        req_valid_i   = 1'b1;
        req_decrypt_i = 1'b1;
        req_data_i    = CT2;
        req_key_i     = KEY2;
        stable_ok     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_data_o !== CT1 || req_ready_o !== 1'b0 || rsp_valid_o !== 1'b1)
                stable_ok = 1'b0;
        end
        checkOutput("bp_stable", 64'(stable_ok), 64'd1);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        checkOutput("bp_idle_no_start", 64'(rnd_start_o), 64'd0);
        checkOutput("bp_idle_ready", 64'(req_ready_o), 64'd1);
        applyStimulus(1'b1, CT2, KEY2);
        runToDone(1'b1, CT2, KEY2);
        checkOutput("bp_second_latency", 64'(lat), 64'd19);
        checkOutput("bp_second_result", rsp_data_o, PT2);
        finishResponse();

        // Reset in the middle of round 7
        applyStimulus(1'b0, PT1, KEY1);
        waited = 0;
        while (rnd_iter_o != 4'd7 && waited < 30) begin
            step();
            waited++;
        end
        checkOutput("mid_reached_round7", 64'({rnd_en_o, rnd_iter_o}), 64'h17);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_busy", 64'(busy_o), 64'd0);
        checkOutput("mid_rst_en", 64'(rnd_en_o), 64'd0);
        checkOutput("mid_rst_iter", 64'(rnd_iter_o), 64'd0);
        checkOutput("mid_rst_shift", 64'(rnd_shift_o), 64'd0);
        checkOutput("mid_rst_key", rnd_key_o, 64'd0);
        checkOutput("mid_rst_rsp_data", rsp_data_o, 64'd0);
        step();
        reset = 1'b0;
        #1;
        checkOutput("mid_release_ready", 64'(req_ready_o), 64'd1);
        step();
        step();
        checkOutput("mid_no_response", 64'({rsp_valid_o, busy_o}), 64'd0);
        applyStimulus(1'b0, PT2, KEY2);
        runToDone(1'b0, PT2, KEY2);
        checkOutput("mid_after_result", rsp_data_o, CT2);
        checkOutput("mid_after_latency", 64'(lat), 64'd19);
        finishResponse();

        // Back-to-back with req_valid_i held high and rsp_ready_i tied high
        rsp_ready_i   = 1'b1;
        req_valid_i   = 1'b1;
        req_decrypt_i = 1'b0;
        req_data_i    = PT1;
        req_key_i     = KEY1;
        n_rsp = 0; cyc = 0; switched = 1'b0;
        rsp_cyc[0] = 0; rsp_cyc[1] = 0; rsp_val[0] = '0; rsp_val[1] = '0;
        while (n_rsp < 2 && cyc < 80) begin
            step();
            cyc++;
            if (busy_o && !switched) begin
                switched      = 1'b1;
                req_decrypt_i = 1'b1;
                req_data_i    = CT1;
            end
            if (rsp_valid_o) begin
                rsp_cyc[n_rsp] = cyc;
                rsp_val[n_rsp] = rsp_data_o;
                n_rsp++;
            end
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        checkOutput("b2b_first_result", rsp_val[0], CT1);
        checkOutput("b2b_second_result", rsp_val[1], PT1);
        checkOutput("b2b_first_cycle", 64'(rsp_cyc[0]), 64'd19);
        checkOutput("b2b_spacing", 64'(rsp_cyc[1] - rsp_cyc[0]), 64'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
